// File: rtl/complex_mul_flat.sv
// Fully parallel 3-stage pipelined complex multiplier, z = x*y, 18-bit signed I/Q.
// Define COMPLEX_MUL_FLAT_ROUND_EN for round-half-up scaling instead of floor.
module complex_mul_flat (
    input  logic               clk,
    input  logic               rst,
    input  logic               gate_in,
    input  logic signed [17:0] x_I,
    input  logic signed [17:0] x_Q,
    input  logic signed [17:0] y_I,
    input  logic signed [17:0] y_Q,
    output logic signed [17:0] z_I,
    output logic signed [17:0] z_Q,
    output logic               gate_out
);

    localparam int unsigned DW = 18;
    localparam int unsigned PW = 36;
    localparam int unsigned SW = 37;
    localparam int unsigned AW = 38;
    localparam int unsigned SHIFT = 17;

    logic signed [PW-1:0] p_ii;
    logic signed [PW-1:0] p_qq;
    logic signed [PW-1:0] p_iq;
    logic signed [PW-1:0] p_qi;
    logic signed [SW-1:0] sum_re;
    logic signed [SW-1:0] sum_im;
    logic [2:0]           gate_d;

    // Scale by 2^-17 (floor or round half up) at 38 bits, then clip to 18 bits.
    function automatic logic signed [DW-1:0] scale_sat(input logic signed [SW-1:0] s);
        logic signed [AW-1:0] adj;
        logic signed [AW-1:0] shifted;
`ifdef COMPLEX_MUL_FLAT_ROUND_EN
        adj = AW'(s) + 38'sd65536;
`else
        adj = AW'(s);
`endif
        shifted = adj >>> SHIFT;
        if (shifted > 38'sd131071) begin
            scale_sat = 18'sd131071;
        end else if (shifted < -38'sd131072) begin
            scale_sat = -18'sd131072;
        end else begin
            scale_sat = shifted[DW-1:0];
        end
    endfunction

    // Stage 1: four full-precision products.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_ii <= '0;
            p_qq <= '0;
            p_iq <= '0;
            p_qi <= '0;
        end else begin
            p_ii <= PW'(x_I) * PW'(y_I);
            p_qq <= PW'(x_Q) * PW'(y_Q);
            p_iq <= PW'(x_I) * PW'(y_Q);
            p_qi <= PW'(x_Q) * PW'(y_I);
        end
    end

    // Stage 2: 37-bit sums hold the 2^35 extreme without wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_re <= '0;
            sum_im <= '0;
        end else begin
            sum_re <= SW'(p_ii) - SW'(p_qq);
            sum_im <= SW'(p_iq) + SW'(p_qi);
        end
    end

    // Stage 3: scaled, saturated outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_I <= '0;
            z_Q <= '0;
        end else begin
            z_I <= scale_sat(sum_re);
            z_Q <= scale_sat(sum_im);
        end
    end

    // Gate flag pipeline matched to the datapath depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_d <= '0;
        end else begin
            gate_d <= {gate_d[1:0], gate_in};
        end
    end

    assign gate_out = gate_d[2];

endmodule

// File: tb/tb_complex_mul_flat.sv
// Directed-vector and soak bench for complex_mul_flat (both rounding variants).
module tb_complex_mul_flat;

`ifdef COMPLEX_MUL_FLAT_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic               clk;
    logic               rst;
    logic               gate_in;
    logic signed [17:0] x_I, x_Q, y_I, y_Q;
    logic signed [17:0] z_I, z_Q;
    logic               gate_out;

    int n_cmp;
    int n_fail;

    complex_mul_flat dut (
        .clk(clk), .rst(rst), .gate_in(gate_in),
        .x_I(x_I), .x_Q(x_Q), .y_I(y_I), .y_Q(y_Q),
        .z_I(z_I), .z_Q(z_Q), .gate_out(gate_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic signed [17:0] xi, xq, yi, yq;
        int                 ei, eq;
    } vec_t;

    logic   hg [0:127];
    longint hre [0:127];
    longint him [0:127];
    int     hn;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint exp_z(input longint s);
        longint t;
        t = RND ? ((s + 64'sd65536) >>> 17) : (s >>> 17);
        if (t > 131071) t = 131071;
        if (t < -131072) t = -131072;
        return t;
    endfunction

    task automatic tol_chk(input string name, input longint z, input longint s);
        longint r, d;
        r = s;
        if (r > 64'sd131072 * 64'sd131071) r = 64'sd131072 * 64'sd131071;
        if (r < -64'sd131072 * 64'sd131072) r = -64'sd131072 * 64'sd131072;
        d = z * 64'sd131072 - r;
        n_cmp++;
        if (d > 131072 || d < -131072) begin
            n_fail++;
            $display("FAIL %s: got z=%0d for exact sum %0d (error %0d)", name, z, r, d);
        end
    endtask

    task automatic drive(input logic g, input logic signed [17:0] a, b, c, d);
        gate_in = g; x_I = a; x_Q = b; y_I = c; y_Q = d;
    endtask

    // One streamed cycle: outputs after this edge belong to the vector sampled two edges earlier.
    task automatic step(input logic g, input logic signed [17:0] a, b, c, d, input bit exact);
        int m;
        @(negedge clk);
        drive(g, a, b, c, d);
        hg[hn]  = g;
        hre[hn] = longint'(a) * longint'(c) - longint'(b) * longint'(d);
        him[hn] = longint'(a) * longint'(d) + longint'(b) * longint'(c);
        @(posedge clk);
        #1;
        if (hn >= 2) begin
            m = hn - 2;
            chk("stream_gate", longint'(gate_out), longint'(hg[m]));
            if (exact) begin
                chk("stream_zi", longint'(z_I), exp_z(hre[m]));
                chk("stream_zq", longint'(z_Q), exp_z(him[m]));
            end else if (hg[m]) begin
                tol_chk("soak_zi", longint'(z_I), hre[m]);
                tol_chk("soak_zq", longint'(z_Q), him[m]);
            end
        end
        hn++;
    endtask

    vec_t tbl [0:6];
    logic signed [17:0] r0, r1, r2, r3;
    logic signed [17:0] gpat [0:3];
    int edges;

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst = 1'b1;
        drive(1'b0, '0, '0, '0, '0);

        tbl[0] = '{18'sd65536, 18'sd0, 18'sd65536, 18'sd0, 32768, 0};
        tbl[1] = '{18'sd0, 18'sd65536, 18'sd0, 18'sd65536, -32768, 0};
        tbl[2] = '{18'sd65536, 18'sd0, 18'sd0, 18'sd65536, 0, 32768};
        tbl[3] = '{-18'sd131072, -18'sd131072, -18'sd131072, -18'sd131072, 0, 131071};
        tbl[4] = '{-18'sd131072, 18'sd131071, 18'sd131071, 18'sd131071, -131072, -1};
        tbl[5] = '{18'sd131071, 18'sd0, 18'sd131071, 18'sd0, 131070, 0};
        tbl[6] = '{-18'sd1, 18'sd0, 18'sd1, 18'sd0, RND ? 0 : -1, 0};

        // Reset held with live random stimulus.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(1'b1, 18'($urandom), 18'($urandom), 18'($urandom), 18'($urandom));
            @(posedge clk);
            #1;
            chk("rst_hold_zi", longint'(z_I), 0);
            chk("rst_hold_zq", longint'(z_Q), 0);
            chk("rst_hold_gate", longint'(gate_out), 0);
        end

        // Release and measure first gate latency.
        @(negedge clk);
        drive(1'b0, '0, '0, '0, '0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        gate_in = 1'b1;
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            gate_in = 1'b0;
            edges++;
        end while (!gate_out && edges < 10);
        chk("first_gate_latency", longint'(edges), 3);
        repeat (3) @(posedge clk);

        // Table-driven single-pulse vectors with exact latency checks.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive(1'b1, tbl[i].xi, tbl[i].xq, tbl[i].yi, tbl[i].yq);
            @(posedge clk);
            #1;
            drive(1'b0, '0, '0, '0, '0);
            @(posedge clk);
            #1;
            chk("vec_gate_early", longint'(gate_out), 0);
            @(posedge clk);
            #1;
            chk("vec_zi", longint'(z_I), longint'(tbl[i].ei));
            chk("vec_zq", longint'(z_Q), longint'(tbl[i].eq));
            chk("vec_gate", longint'(gate_out), 1);
            @(posedge clk);
            #1;
            chk("vec_gate_after", longint'(gate_out), 0);
        end

        // Async reset between edges with a result on the outputs.
        @(negedge clk);
        drive(1'b1, 18'sd65536, '0, 18'sd65536, '0);
        @(posedge clk);
        #1;
        drive(1'b0, '0, '0, '0, '0);
        repeat (2) @(posedge clk);
        #2;
        chk("async_pre_zi", longint'(z_I), 32768);
        rst = 1'b1;
        #1;
        chk("async_zi", longint'(z_I), 0);
        chk("async_gate", longint'(gate_out), 0);
        @(negedge clk);
        rst = 1'b0;

        // Async reset with data still in stages 1-2 must flush it.
        @(negedge clk);
        drive(1'b1, 18'sd65536, 18'sd1000, 18'sd65536, 18'sd2000);
        @(posedge clk);
        #2;
        drive(1'b0, '0, '0, '0, '0);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("flush_zi", longint'(z_I), 0);
            chk("flush_zq", longint'(z_Q), 0);
            chk("flush_gate", longint'(gate_out), 0);
        end

        // Gate pattern 1,1,0,1 with distinct data, aligned with z.
        gpat[0] = 1'b1; gpat[1] = 1'b1; gpat[2] = 1'b0; gpat[3] = 1'b1;
        hn = 0;
        for (int i = 0; i < 4; i++) begin
            r0 = 18'(1000 * (i + 1));
            r1 = 18'(-700 * (i + 2));
            r2 = 18'(40000 + i * 9000);
            r3 = 18'(-30000 + i * 5000);
            step(gpat[i], r0, r1, r2, r3, 1'b1);
        end
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, '0, '0, 1'b1);

        // Random soak, gate every 4th cycle, tolerance check at each gate_out.
        hn = 0;
        for (int i = 0; i < 64; i++) begin
            r0 = 18'($urandom); r1 = 18'($urandom);
            r2 = 18'($urandom); r3 = 18'($urandom);
            if (i % 16 == 8) begin
                r0 = -18'sd131072; r3 = -18'sd131072;
            end
            step((i % 4) == 0, r0, r1, r2, r3, 1'b0);
        end
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, '0, '0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
